// File: rtl/mem_boot_ctrl_pkg.sv
// mem_boot_ctrl_pkg
//   Shared sizing constants and FSM state encoding for the boot loader.
//   MBC_ADDR_W     : BRAM byte address width
//   MBC_DATA_WIDTH : BRAM word width
//   MBC_MAX_WORDS  : largest legal word count per BRAM
package mem_boot_ctrl_pkg;

    localparam int MBC_ADDR_W     = 12;
    localparam int MBC_DATA_WIDTH = 32;
    localparam int MBC_MAX_WORDS  = 1024;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_D = 3'd1,
        ST_LOAD_I = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_RUN    = 3'd4
    } state_t;

endpackage

// File: rtl/bram_wport_mux.sv
// bram_wport_mux
//   2:1 select of a BRAM write port (addr / data / enable / byte enables).
//   i_sel  : 0 selects port A, 1 selects port B
//   i_a_*  : port A write request
//   i_b_*  : port B write request
//   o_*    : selected write request, purely combinational
module bram_wport_mux #(
    parameter int ADDR_W     = 12,
    parameter int DATA_WIDTH = 32,
    localparam int BE_W      = DATA_WIDTH / 8
) (
    input  logic                  i_sel,
    input  logic [ADDR_W-1:0]     i_a_addr,
    input  logic [DATA_WIDTH-1:0] i_a_dat,
    input  logic                  i_a_enb,
    input  logic [BE_W-1:0]       i_a_byte_enb,
    input  logic [ADDR_W-1:0]     i_b_addr,
    input  logic [DATA_WIDTH-1:0] i_b_dat,
    input  logic                  i_b_enb,
    input  logic [BE_W-1:0]       i_b_byte_enb,
    output logic [ADDR_W-1:0]     o_addr,
    output logic [DATA_WIDTH-1:0] o_dat,
    output logic                  o_enb,
    output logic [BE_W-1:0]       o_byte_enb
);

    assign o_addr     = i_sel ? i_b_addr     : i_a_addr;
    assign o_dat      = i_sel ? i_b_dat      : i_a_dat;
    assign o_enb      = i_sel ? i_b_enb      : i_a_enb;
    assign o_byte_enb = i_sel ? i_b_byte_enb : i_a_byte_enb;

endmodule

// File: rtl/mem_boot_ctrl.sv
// mem_boot_ctrl
//   Streams a boot image into the data BRAM (d_count words) and then the
//   instruction BRAM (i_count words), holding the core's PC meanwhile, and
//   hands the data BRAM write port to the core once loading is complete.
//   clk, rst                : clock, asynchronous active-low reset
//   start, d_count, i_count : load request and word counts
//   in_valid/in_dat/in_ready: boot word stream (valid/ready)
//   i_w_*                   : instruction BRAM write port
//   core_d_*                : core store request
//   d_w_*                   : data BRAM write port (loader or core)
//   pc_stall, core_sel      : core hold / core owns data write port
//   done, err               : core running / count out of range
module mem_boot_ctrl
    import mem_boot_ctrl_pkg::*;
#(
    parameter int ADDR_W     = MBC_ADDR_W,
    parameter int DATA_WIDTH = MBC_DATA_WIDTH,
    parameter int MAX_WORDS  = MBC_MAX_WORDS,
    localparam int CNT_W     = $clog2(MAX_WORDS) + 1,
    localparam int BE_W      = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CNT_W-1:0]      d_count,
    input  logic [CNT_W-1:0]      i_count,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_dat,
    output logic                  in_ready,
    output logic [ADDR_W-1:0]     i_w_addr,
    output logic [DATA_WIDTH-1:0] i_w_dat,
    output logic                  i_w_enb,
    output logic [BE_W-1:0]       i_w_byte_enb,
    input  logic [ADDR_W-1:0]     core_d_addr,
    input  logic [DATA_WIDTH-1:0] core_d_dat,
    input  logic                  core_d_enb,
    input  logic [BE_W-1:0]       core_d_byte_enb,
    output logic [ADDR_W-1:0]     d_w_addr,
    output logic [DATA_WIDTH-1:0] d_w_dat,
    output logic                  d_w_enb,
    output logic [BE_W-1:0]       d_w_byte_enb,
    output logic                  pc_stall,
    output logic                  core_sel,
    output logic                  done,
    output logic                  err
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      r_dcnt;
    logic [CNT_W-1:0]      r_icnt;
    logic                  r_err;
    logic                  r_pc_stall;
    logic                  r_core_sel;
    logic                  r_done;
    logic                  r_ld_d_enb;
    logic                  r_ld_i_enb;
    logic [ADDR_W-1:0]     r_ld_addr;
    logic [DATA_WIDTH-1:0] r_ld_dat;

    logic                  w_loading;
    logic [CNT_W-1:0]      w_lim;
    logic                  w_in_ready;
    logic                  w_hs;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic                  w_seg_done;
    logic                  w_range_ok;
    logic [ADDR_W-1:0]     w_word_addr;

    // Counts are latched at start so the stream limits cannot shift mid-load.
    assign w_loading   = (r_state == ST_LOAD_D) || (r_state == ST_LOAD_I);
    assign w_lim       = (r_state == ST_LOAD_I) ? r_icnt : r_dcnt;
    assign w_in_ready  = w_loading && (r_cnt < w_lim);
    assign w_hs        = in_valid && w_in_ready;
    assign w_cnt_nxt   = r_cnt + {{(CNT_W-1){1'b0}}, w_hs};
    // Segment ends on the handshake that fills it (or at once for a zero
    // count), so DRAIN coincides with the final loader write cycle.
    assign w_seg_done  = w_loading && (w_cnt_nxt == w_lim);
    assign w_range_ok  = (d_count <= MAX_CNT) && (i_count <= MAX_CNT);
    // Byte address = 4 * word index, wrapping at the address width.
    assign w_word_addr = ADDR_W'({r_cnt, 2'b00});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_dcnt     <= '0;
            r_icnt     <= '0;
            r_err      <= 1'b0;
            r_pc_stall <= 1'b1;
            r_core_sel <= 1'b0;
            r_done     <= 1'b0;
            r_ld_d_enb <= 1'b0;
            r_ld_i_enb <= 1'b0;
            r_ld_addr  <= '0;
            r_ld_dat   <= '0;
        end else begin
            r_ld_d_enb <= w_hs && (r_state == ST_LOAD_D);
            r_ld_i_enb <= w_hs && (r_state == ST_LOAD_I);
            if (w_hs) begin
                r_ld_addr <= w_word_addr;
                r_ld_dat  <= in_dat;
                r_cnt     <= w_cnt_nxt;
            end

            unique case (r_state)
                ST_IDLE, ST_RUN: begin
                    if (start) begin
                        // A rejected start from RUN still drops the core back
                        // to a stalled IDLE.
                        r_pc_stall <= 1'b1;
                        r_core_sel <= 1'b0;
                        r_done     <= 1'b0;
                        if (!w_range_ok) begin
                            r_err   <= 1'b1;
                            r_state <= ST_IDLE;
                        end else begin
                            r_err   <= 1'b0;
                            r_cnt   <= '0;
                            r_dcnt  <= d_count;
                            r_icnt  <= i_count;
                            r_state <= ST_LOAD_D;
                        end
                    end
                end
                ST_LOAD_D: begin
                    if (w_seg_done) begin
                        r_cnt   <= '0;
                        r_state <= ST_LOAD_I;
                    end
                end
                ST_LOAD_I: begin
                    if (w_seg_done) begin
                        r_cnt   <= '0;
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    r_state    <= ST_RUN;
                    r_pc_stall <= 1'b0;
                    r_core_sel <= 1'b1;
                    r_done     <= 1'b1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready     = w_in_ready;
    assign i_w_addr     = r_ld_addr;
    assign i_w_dat      = r_ld_dat;
    assign i_w_enb      = r_ld_i_enb;
    assign i_w_byte_enb = {BE_W{r_ld_i_enb}};
    assign pc_stall     = r_pc_stall;
    assign core_sel     = r_core_sel;
    assign done         = r_done;
    assign err          = r_err;

    // Core stores only reach the BRAM while core_sel is high.
    bram_wport_mux #(
        .ADDR_W     (ADDR_W),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_dmux (
        .i_sel        (r_core_sel),
        .i_a_addr     (r_ld_addr),
        .i_a_dat      (r_ld_dat),
        .i_a_enb      (r_ld_d_enb),
        .i_a_byte_enb ({BE_W{r_ld_d_enb}}),
        .i_b_addr     (core_d_addr),
        .i_b_dat      (core_d_dat),
        .i_b_enb      (core_d_enb),
        .i_b_byte_enb (core_d_byte_enb),
        .o_addr       (d_w_addr),
        .o_dat        (d_w_dat),
        .o_enb        (d_w_enb),
        .o_byte_enb   (d_w_byte_enb)
    );

endmodule
